irq_controller: RTL and testbench

- Memory-mapped interrupt controller that collects up to NUM_SRC external interrupt sources and drives the core's active-low nIRQ input.
- Sits on the processor data bus beside data memory and decodes its own address window at BASE_ADDR.
- Provides per-source enable, edge/level mode, write-1-to-clear pending, a claim register returning the highest-priority ID, and an end-of-interrupt register.
- Sequences interrupt delivery so that only one interrupt is in service at a time.

---
 rtl/irq_pkg.sv | 22 ++
 rtl/irq_sync_edge.sv | 32 +++
 rtl/irq_controller.sv | 193 +++++++++++++++++++
 tb/tb_irq_controller.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared constants and types for the memory-mapped interrupt controller.
package irq_pkg;

  // Register offsets within the 32-byte window (byte addresses, word aligned).
  localparam logic [4:0] OFF_PENDING = 5'h00;
  localparam logic [4:0] OFF_ENABLE  = 5'h04;
  localparam logic [4:0] OFF_MODE    = 5'h08;
  localparam logic [4:0] OFF_CLAIM   = 5'h0C;
  localparam logic [4:0] OFF_EOI     = 5'h10;

  // Claim value returned when no enabled source is pending.
  localparam logic [31:0] ID_NONE = 32'hFFFF_FFFF;

  // Delivery sequencer: wait for a request, hold nIRQ low until claimed,
  // then block further delivery until end-of-interrupt.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source input conditioning: two-flop synchronizer for an asynchronous
// request line, plus a delayed copy used to detect rising edges.
module irq_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_irq,
  output logic o_sync,
  output logic o_edge
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronizer chain and one-cycle-delayed copy of the synchronized level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_irq;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  // High for exactly one cycle after the synchronized level rises.
  assign o_edge = r_sync & ~r_prev;

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: collects NUM_SRC request lines,
// prioritises them (source 0 highest) and drives the core's active-low nIRQ,
// allowing only one interrupt in service at a time.
module irq_controller #(
  parameter int          NUM_SRC   = 8,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [31:0]        addr,
  input  logic               we,
  input  logic               re,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               sel,
  output logic               nIRQ
);

  import irq_pkg::*;

  // Conditioned source signals.
  logic [NUM_SRC-1:0] w_sync;
  logic [NUM_SRC-1:0] w_edge;

  // Architectural state.
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_enable;
  logic [NUM_SRC-1:0] r_mode;
  logic [31:0]        r_active_id;
  irq_state_t         r_state;
  logic               r_nirq;

  // Decode and next-state values.
  logic               w_sel;
  logic [4:0]         w_off;
  logic               w_wr_pending;
  logic               w_wr_enable;
  logic               w_wr_mode;
  logic               w_wr_eoi;
  logic               w_rd_claim;
  logic [NUM_SRC-1:0] w_active;
  logic               w_req;
  logic [31:0]        w_best_id;
  logic               w_claim_take;
  logic [NUM_SRC-1:0] w_claim_mask;
  logic [NUM_SRC-1:0] w_w1c;
  logic [NUM_SRC-1:0] w_enable_next;
  logic [NUM_SRC-1:0] w_mode_next;
  logic [NUM_SRC-1:0] w_pending_next;
  irq_state_t         w_state_next;
  logic [31:0]        w_rdata;
  logic               w_unused_ok;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      irq_sync_edge u_sync_edge (
        .clk    (clk),
        .reset  (reset),
        .i_irq  (irq_src[gi]),
        .o_sync (w_sync[gi]),
        .o_edge (w_edge[gi])
      );
    end
  endgenerate

  // Window and register decode; byte lanes are not decoded.
  assign w_sel        = (addr[31:5] == BASE_ADDR[31:5]);
  assign w_off        = addr[4:0];
  assign w_wr_pending = w_sel & we & (w_off == OFF_PENDING);
  assign w_wr_enable  = w_sel & we & (w_off == OFF_ENABLE);
  assign w_wr_mode    = w_sel & we & (w_off == OFF_MODE);
  assign w_wr_eoi     = w_sel & we & (w_off == OFF_EOI);
  assign w_rd_claim   = w_sel & re & (w_off == OFF_CLAIM);

  assign w_active = r_pending & r_enable;
  assign w_req    = |w_active;

  // Priority encoder: lowest-numbered enabled pending source wins.
  always_comb begin
    w_best_id = ID_NONE;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_active[i]) begin
        w_best_id = 32'(i);
      end
    end
  end

  // A claim only has side effects while a request is being presented.
  assign w_claim_take = w_rd_claim & w_req & (r_state == REQ);

  // One-hot of the source being claimed, used to clear its edge-mode bit.
  always_comb begin
    w_claim_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_claim_mask[i] = w_claim_take && (w_best_id == 32'(i));
    end
  end

  assign w_w1c         = w_wr_pending ? wdata[NUM_SRC-1:0] : '0;
  assign w_enable_next = w_wr_enable  ? wdata[NUM_SRC-1:0] : r_enable;
  assign w_mode_next   = w_wr_mode    ? wdata[NUM_SRC-1:0] : r_mode;

  // Pending update per source; the mode in force this cycle selects the rule,
  // and a switch into edge mode discards any level-derived pending state.
  always_comb begin
    w_pending_next = r_pending;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_mode_next[i] && !r_mode[i]) begin
        w_pending_next[i] = 1'b0;
      end else if (!r_mode[i]) begin
        w_pending_next[i] = w_sync[i];
      end else if (w_edge[i]) begin
        // A fresh edge beats a simultaneous clear so no event is lost.
        w_pending_next[i] = 1'b1;
      end else if (w_w1c[i] || w_claim_mask[i]) begin
        w_pending_next[i] = 1'b0;
      end
    end
  end

  // Delivery sequencer next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_state_next = REQ;
        end
      end
      REQ: begin
        if (!w_req) begin
          w_state_next = IDLE;
        end else if (w_rd_claim) begin
          w_state_next = SERVICE;
        end
      end
      SERVICE: begin
        if (w_wr_eoi) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Register state; nIRQ is decoded from the next state so it is a clean flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending   <= '0;
      r_enable    <= '0;
      r_mode      <= '0;
      r_active_id <= '0;
      r_state     <= IDLE;
      r_nirq      <= 1'b1;
    end else begin
      r_pending <= w_pending_next;
      r_enable  <= w_enable_next;
      r_mode    <= w_mode_next;
      if (w_claim_take) begin
        r_active_id <= w_best_id;
      end
      r_state <= w_state_next;
      r_nirq  <= (w_state_next != REQ);
    end
  end

  // Read mux; unmapped offsets and bits above NUM_SRC read as zero.
  always_comb begin
    w_rdata = '0;
    if (w_sel) begin
      case (w_off)
        OFF_PENDING: w_rdata[NUM_SRC-1:0] = r_pending;
        OFF_ENABLE:  w_rdata[NUM_SRC-1:0] = r_enable;
        OFF_MODE:    w_rdata[NUM_SRC-1:0] = r_mode;
        OFF_CLAIM:   w_rdata = w_best_id;
        default:     w_rdata = '0;
      endcase
    end
  end

  // The latched ID is kept for debug visibility; upper write-data bits are
  // simply ignored when NUM_SRC < 32.
  assign w_unused_ok = ^{r_active_id, wdata};

  assign rdata = w_rdata;
  assign sel   = w_sel;
  assign nIRQ  = r_nirq;

endmodule

// File: tb/tb_irq_controller.sv
// Directed, table-driven bench for irq_controller plus hand-written
// sequences for masking, spurious accesses and reset during a request.
module tb_irq_controller;

  import irq_pkg::*;

  localparam logic [31:0] B = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  irq_src = '0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        sel;
  logic        nIRQ;

  int checks = 0;
  int errors = 0;

  irq_controller #(
    .NUM_SRC   (8),
    .BASE_ADDR (B)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .irq_src (irq_src),
    .addr    (addr),
    .we      (we),
    .re      (re),
    .wdata   (wdata),
    .rdata   (rdata),
    .sel     (sel),
    .nIRQ    (nIRQ)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  irq;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_sel;
    logic        exp_nirq;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t vraw(logic w, logic r, logic [31:0] a, logic [31:0] d,
                                logic [7:0] irq, logic chk, logic [31:0] exp,
                                logic s, logic n);
    vec_t v;
    v.we = w; v.re = r; v.addr = a; v.wdata = d; v.irq = irq;
    v.chk_rd = chk; v.exp_rd = exp; v.exp_sel = s; v.exp_nirq = n;
    return v;
  endfunction

  function automatic vec_t vrd(logic [4:0] off, logic [31:0] exp, logic [7:0] irq, logic n);
    return vraw(1'b0, 1'b1, B + 32'(off), 32'd0, irq, 1'b1, exp, 1'b1, n);
  endfunction

  function automatic vec_t vwr(logic [4:0] off, logic [31:0] d, logic [7:0] irq, logic n);
    return vraw(1'b1, 1'b0, B + 32'(off), d, irq, 1'b0, 32'd0, 1'b1, n);
  endfunction

  function automatic vec_t vnop(logic [7:0] irq, logic n);
    return vraw(1'b0, 1'b0, 32'd0, 32'd0, irq, 1'b1, 32'd0, 1'b0, n);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one bus cycle at the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic [7:0] irq);
    @(negedge clk);
    we = w; re = r; addr = a; wdata = d; irq_src = irq;
    #1;
  endtask

  task automatic idle(input logic [7:0] irq);
    drive(1'b0, 1'b0, 32'd0, 32'd0, irq);
  endtask

  task automatic bus_wr(input logic [4:0] off, input logic [31:0] d);
    drive(1'b1, 1'b0, B + 32'(off), d, 8'h00);
    $display("wr  off=%h data=%h nIRQ=%b", off, d, nIRQ);
  endtask

  task automatic bus_rd_check(input string name, input logic [4:0] off, input logic [31:0] exp);
    drive(1'b0, 1'b1, B + 32'(off), 32'd0, 8'h00);
    $display("rd  off=%h data=%h nIRQ=%b", off, rdata, nIRQ);
    check(name, rdata, exp);
  endtask

  task automatic wait_nirq_low(input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      idle(8'h00);
      if (nIRQ == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: nIRQ got 1 after 10 cycles expected 0", name);
    end
  endtask

  initial begin
    // Reset state, edge-latency, claim/EOI.
    vecs.push_back(vrd(OFF_PENDING, 32'h0, 8'h00, 1'b1));          // 0
    vecs.push_back(vrd(OFF_ENABLE, 32'h0, 8'h00, 1'b1));           // 1
    vecs.push_back(vrd(OFF_MODE, 32'h0, 8'h00, 1'b1));             // 2
    vecs.push_back(vrd(OFF_CLAIM, ID_NONE, 8'h00, 1'b1));          // 3
    vecs.push_back(vwr(OFF_ENABLE, 32'hFFFF_FF08, 8'h00, 1'b1));   // 4
    vecs.push_back(vwr(OFF_MODE, 32'h08, 8'h00, 1'b1));            // 5
    vecs.push_back(vrd(OFF_ENABLE, 32'h08, 8'h00, 1'b1));          // 6 upper bits read 0
    vecs.push_back(vrd(OFF_MODE, 32'h08, 8'h08, 1'b1));            // 7 irq3 sampled here
    vecs.push_back(vrd(OFF_PENDING, 32'h0, 8'h00, 1'b1));          // 8
    vecs.push_back(vrd(OFF_PENDING, 32'h0, 8'h00, 1'b1));          // 9
    vecs.push_back(vrd(OFF_PENDING, 32'h08, 8'h00, 1'b1));         // 10 set at k+2
    vecs.push_back(vrd(OFF_PENDING, 32'h08, 8'h00, 1'b0));         // 11 nIRQ low at k+3
    vecs.push_back(vrd(OFF_CLAIM, 32'd3, 8'h00, 1'b0));            // 12 claim
    vecs.push_back(vrd(OFF_PENDING, 32'h0, 8'h00, 1'b1));          // 13
    vecs.push_back(vwr(OFF_EOI, 32'h0, 8'h00, 1'b1));              // 14
    vecs.push_back(vrd(OFF_CLAIM, ID_NONE, 8'h00, 1'b1));          // 15
    vecs.push_back(vnop(8'h00, 1'b1));                             // 16
    // Priority between sources 1 and 5.
    vecs.push_back(vwr(OFF_ENABLE, 32'h22, 8'h00, 1'b1));          // 17
    vecs.push_back(vwr(OFF_MODE, 32'h22, 8'h00, 1'b1));            // 18
    vecs.push_back(vnop(8'h22, 1'b1));                             // 19
    vecs.push_back(vnop(8'h00, 1'b1));                             // 20
    vecs.push_back(vnop(8'h00, 1'b1));                             // 21
    vecs.push_back(vrd(OFF_PENDING, 32'h22, 8'h00, 1'b1));         // 22
    vecs.push_back(vrd(OFF_CLAIM, 32'd1, 8'h00, 1'b0));            // 23
    vecs.push_back(vrd(OFF_PENDING, 32'h20, 8'h00, 1'b1));         // 24
    vecs.push_back(vrd(OFF_CLAIM, 32'd5, 8'h00, 1'b1));            // 25 no side effect
    vecs.push_back(vrd(OFF_PENDING, 32'h20, 8'h00, 1'b1));         // 26
    vecs.push_back(vwr(OFF_EOI, 32'h0, 8'h00, 1'b1));              // 27
    vecs.push_back(vnop(8'h00, 1'b1));                             // 28 re-evaluate
    vecs.push_back(vrd(OFF_CLAIM, 32'd5, 8'h00, 1'b0));            // 29
    vecs.push_back(vrd(OFF_PENDING, 32'h0, 8'h00, 1'b1));          // 30
    vecs.push_back(vwr(OFF_EOI, 32'h0, 8'h00, 1'b1));              // 31
    // Level mode on source 0.
    vecs.push_back(vwr(OFF_MODE, 32'h00, 8'h00, 1'b1));            // 32
    vecs.push_back(vwr(OFF_ENABLE, 32'h01, 8'h01, 1'b1));          // 33
    vecs.push_back(vnop(8'h01, 1'b1));                             // 34
    vecs.push_back(vnop(8'h01, 1'b1));                             // 35
    vecs.push_back(vrd(OFF_PENDING, 32'h01, 8'h01, 1'b1));         // 36
    vecs.push_back(vrd(OFF_CLAIM, 32'd0, 8'h01, 1'b0));            // 37
    vecs.push_back(vwr(OFF_PENDING, 32'h01, 8'h01, 1'b1));         // 38 W1C ignored
    vecs.push_back(vrd(OFF_PENDING, 32'h01, 8'h01, 1'b1));         // 39
    vecs.push_back(vwr(OFF_EOI, 32'h0, 8'h01, 1'b1));              // 40
    vecs.push_back(vnop(8'h01, 1'b1));                             // 41
    vecs.push_back(vnop(8'h00, 1'b0));                             // 42 drop irq0
    vecs.push_back(vrd(OFF_PENDING, 32'h01, 8'h00, 1'b0));         // 43
    vecs.push_back(vrd(OFF_PENDING, 32'h01, 8'h00, 1'b0));         // 44
    vecs.push_back(vrd(OFF_PENDING, 32'h00, 8'h00, 1'b0));         // 45
    vecs.push_back(vnop(8'h00, 1'b1));                             // 46
    // W1C / new-edge collision on source 2 (left disabled).
    vecs.push_back(vwr(OFF_MODE, 32'h04, 8'h00, 1'b1));            // 47
    vecs.push_back(vnop(8'h04, 1'b1));                             // 48
    vecs.push_back(vnop(8'h00, 1'b1));                             // 49
    vecs.push_back(vnop(8'h00, 1'b1));                             // 50
    vecs.push_back(vrd(OFF_PENDING, 32'h04, 8'h04, 1'b1));         // 51 second edge
    vecs.push_back(vnop(8'h00, 1'b1));                             // 52
    vecs.push_back(vwr(OFF_PENDING, 32'h04, 8'h00, 1'b1));         // 53 W1C with edge
    vecs.push_back(vrd(OFF_PENDING, 32'h04, 8'h00, 1'b1));         // 54 set wins
    vecs.push_back(vraw(1'b0, 1'b1, B + 32'h20, 32'd0, 8'h00, 1'b1, 32'h0, 1'b0, 1'b1)); // 55
    vecs.push_back(vrd(5'h14, 32'h0, 8'h00, 1'b1));                // 56 unmapped
    vecs.push_back(vwr(OFF_PENDING, 32'h04, 8'h00, 1'b1));         // 57 plain W1C
    vecs.push_back(vrd(OFF_PENDING, 32'h00, 8'h00, 1'b1));         // 58

    reset = 1'b1;
    repeat (3) idle(8'h00);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, vecs[i].irq);
      $display("vec %0d we=%b re=%b addr=%h wdata=%h irq=%h rdata=%h sel=%b nIRQ=%b",
               i, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, vecs[i].irq,
               rdata, sel, nIRQ);
      if (vecs[i].chk_rd) check($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rd);
      check($sformatf("vec%0d sel", i), {31'd0, sel}, {31'd0, vecs[i].exp_sel});
      check($sformatf("vec%0d nIRQ", i), {31'd0, nIRQ}, {31'd0, vecs[i].exp_nirq});
    end

    // Masking in REQ, then spurious CLAIM/EOI in IDLE.
    bus_wr(OFF_ENABLE, 32'h04);
    idle(8'h04);
    wait_nirq_low("mask_reach_req");
    bus_wr(OFF_ENABLE, 32'h00);
    idle(8'h00);
    idle(8'h00);
    check("mask_nirq_high", {31'd0, nIRQ}, 32'd1);
    bus_rd_check("idle_claim_none", OFF_CLAIM, ID_NONE);
    bus_rd_check("idle_pending_kept", OFF_PENDING, 32'h04);
    bus_wr(OFF_EOI, 32'h0);
    idle(8'h00);
    check("idle_eoi_nirq", {31'd0, nIRQ}, 32'd1);
    bus_wr(OFF_ENABLE, 32'h04);
    idle(8'h00);
    check("reenable_nirq_idle", {31'd0, nIRQ}, 32'd1);
    idle(8'h00);
    check("reenable_nirq_req", {31'd0, nIRQ}, 32'd0);
    bus_rd_check("reenable_claim", OFF_CLAIM, 32'd2);
    bus_wr(OFF_EOI, 32'h0);

    // Reset while source 3 is being requested, colliding with a bus write.
    bus_wr(OFF_ENABLE, 32'h08);
    bus_wr(OFF_MODE, 32'h08);
    idle(8'h08);
    wait_nirq_low("rst_reach_req");
    drive(1'b1, 1'b0, B + 32'(OFF_ENABLE), 32'hFF, 8'h00);
    reset = 1'b1;
    idle(8'h00);
    reset = 1'b0;
    $display("reset applied nIRQ=%b", nIRQ);
    check("rst_nirq", {31'd0, nIRQ}, 32'd1);
    bus_rd_check("rst_pending", OFF_PENDING, 32'h0);
    bus_rd_check("rst_enable", OFF_ENABLE, 32'h0);
    bus_rd_check("rst_mode", OFF_MODE, 32'h0);
    bus_rd_check("rst_claim", OFF_CLAIM, ID_NONE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
